// File: rtl/core_ctrl.sv
// core_ctrl -- multi-cycle sequencer for the RV32I core.
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It owns the
// program counter, the instruction register and the registered ALU result.
// It handshakes with the instruction and data memory ports and stops the core
// on illegal instructions or on misaligned control-flow targets.
//
// Ports:
//   clock, reset        core clock; synchronous active-high reset
//   imem_req/addr       fetch request and address (address is always pc)
//   imem_ack/rdata      fetch completion and instruction word
//   instr               instruction register, feeds decoder and regfile reads
//   jal, jalr, branch,
//   mem_read, mem_write,
//   reg_write, illegal  decoder flags for instr
//   imm                 decoded immediate
//   alu_result          combinational ALU output
//   alu_q               registered ALU result (data address / ALU writeback)
//   dmem_req/we/ack     data access handshake (we: 1 = store, 0 = load)
//   rf_we               register-file write enable, one-cycle pulse in WB
//   wb_sel              writeback source: 0 = alu_q, 1 = load data, 2 = pc+4
//   pc                  current program counter
//   instret             retired-instruction counter (wraps)
//   halted              sticky stop indication, cleared only by reset

module core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,

  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,

  output logic [31:0] instr,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        illegal,
  input  logic [31:0] imm,

  input  logic [31:0] alu_result,
  output logic [31:0] alu_q,

  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,

  output logic        rf_we,
  output logic [1:0]  wb_sel,

  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        reset_hold;
  logic [31:0] next_pc_q;
  logic [31:0] next_pc_c;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic        fetch_done;
  logic        mem_done;
  logic        target_misaligned;

  // 32-bit adds; any carry out is dropped so the PC wraps at the top of memory.
  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm;

  // Control-flow target for the instruction in EXEC. jalr clears bit 0 of the
  // ALU sum; a branch is taken when the ALU comparison bit is set.
  always_comb begin
    next_pc_c = pc_plus4;
    if (jal) begin
      next_pc_c = pc_plus_imm;
    end else if (jalr) begin
      next_pc_c = {alu_result[31:1], 1'b0};
    end else if (branch && alu_result[0]) begin
      next_pc_c = pc_plus_imm;
    end
  end

  assign target_misaligned = (next_pc_c[1:0] != 2'b00);

  // A handshake completes only while the matching request is high, so stray
  // acks (including ones arriving while reset is being held) are ignored.
  assign fetch_done = imem_req & imem_ack;
  assign mem_done   = dmem_req & dmem_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (fetch_done) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = illegal ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (target_misaligned) begin
          state_nxt = S_HALT;
        end else if (mem_read || mem_write) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_done) begin
          state_nxt = S_WB;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Remembers that reset was high at the last edge. The state register already
  // sits in FETCH during reset, so this keeps the fetch request low until the
  // first cycle after reset has been released.
  always_ff @(posedge clock) begin
    reset_hold <= reset;
  end

  // Architectural registers. pc and instret only move in WB, so a halt taken
  // from DECODE or EXEC leaves them exactly as they were.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_PC;
      instr     <= 32'h0;
      alu_q     <= 32'h0;
      instret   <= 32'h0;
      next_pc_q <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_done) begin
            instr <= imem_rdata;
          end
        end
        S_EXEC: begin
          alu_q     <= alu_result;
          next_pc_q <= next_pc_c;
        end
        S_WB: begin
          pc      <= next_pc_q;
          instret <= instret + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH) && !reset_hold;
  assign imem_addr = pc;
  assign dmem_req  = (state == S_MEM);
  assign dmem_we   = (state == S_MEM) && mem_write;
  assign halted    = (state == S_HALT);

  // Writes to x0 are suppressed here so the register file never sees them.
  assign rf_we = (state == S_WB) && reg_write && (instr[11:7] != 5'd0);

  always_comb begin
    wb_sel = 2'd0;
    if (!reset_hold) begin
      if (jal || jalr) begin
        wb_sel = 2'd2;
      end else if (mem_read) begin
        wb_sel = 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl -- self-checking bench for core_ctrl.
//
// The bench plays instruction memory, data memory and decoder. Each table row
// describes one instruction (word, decoder flags, immediate, ALU value, memory
// wait cycles) together with the hand-derived next pc and writeback outcome.
// Expected records are queued when a row is driven and compared when the DUT
// has finished the instruction (next fetch request or halt).

module tb_core_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MAXC = 40;

  localparam logic [6:0] F_JAL = 7'b1000000;
  localparam logic [6:0] F_JALR = 7'b0100000;
  localparam logic [6:0] F_BR = 7'b0010000;
  localparam logic [6:0] F_MR = 7'b0001000;
  localparam logic [6:0] F_MW = 7'b0000100;
  localparam logic [6:0] F_RW = 7'b0000010;
  localparam logic [6:0] F_ILL = 7'b0000001;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        jal, jalr, branch, mem_read, mem_write, reg_write, illegal;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic [31:0] alu_q;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [31:0] pc;
  logic [31:0] instret;
  logic        halted;

  core_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .jal(jal), .jalr(jalr), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal), .imm(imm),
    .alu_result(alu_result), .alu_q(alu_q),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc), .instret(instret), .halted(halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] word;
    logic [6:0]  flags;
    logic [31:0] imm;
    logic [31:0] alu;
    int          fetchWait;
    int          memWait;
    logic [31:0] expPc;
    bit          expWe;
    logic [1:0]  expWbSel;
    bit          expHalt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instret;
    int          cycles;
    int          weCount;
    logic [1:0]  wbSel;
    bit          halt;
    int          memCycles;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    bit          done;
    int          cycles;
    logic [31:0] addr0;
    bit          addrMoved;
    int          weCount;
    logic [1:0]  wbSel;
    int          memCycles;
    bit          memBad;
    logic [31:0] pc;
    logic [31:0] instret;
    bit          halted;
    logic [31:0] instr;
  } obs_t;

  vec_t  vecs[$];
  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] modelPc;
  logic [31:0] modelInstret;

  task automatic addVec(input logic [31:0] word, input logic [6:0] flags,
                        input logic [31:0] immv, input logic [31:0] alu,
                        input int fw, input int mw, input logic [31:0] expPc,
                        input bit expWe, input logic [1:0] expWbSel, input bit expHalt);
    vec_t v;
    v.word = word; v.flags = flags; v.imm = immv; v.alu = alu;
    v.fetchWait = fw; v.memWait = mw; v.expPc = expPc;
    v.expWe = expWe; v.expWbSel = expWbSel; v.expHalt = expHalt;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", what, act, exp);
    end
  endtask

  task automatic doReset(input bit checkValues);
    reset = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
    {jal, jalr, branch, mem_read, mem_write, reg_write, illegal} = 7'b0;
    imm = 32'h0; alu_result = 32'h0;
    @(negedge clock);
    if (checkValues) begin
      checkVal("reset pc", pc, RESET_PC);
      checkVal("reset instr", instr, 32'h0);
      checkVal("reset alu_q", alu_q, 32'h0);
      checkVal("reset instret", instret, 32'h0);
      checkVal("reset halted", {31'b0, halted}, 32'h0);
      checkVal("reset imem_req", {31'b0, imem_req}, 32'h0);
      checkVal("reset dmem_req", {31'b0, dmem_req}, 32'h0);
      checkVal("reset dmem_we", {31'b0, dmem_we}, 32'h0);
      checkVal("reset rf_we", {31'b0, rf_we}, 32'h0);
      checkVal("reset wb_sel", {30'b0, wb_sel}, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkVal("post-reset imem_req", {31'b0, imem_req}, 32'h1);
    checkVal("post-reset imem_addr", imem_addr, RESET_PC);
    modelPc = RESET_PC;
    modelInstret = 32'h0;
  endtask

  // Drives one instruction from the current FETCH cycle until the DUT either
  // requests the next fetch or halts. Entered and left at a falling edge.
  task automatic applyStimulus(input int idx, input vec_t v, output obs_t o);
    exp_t e;
    int fc, mc;
    bit leftFetch, isMem;
    isMem = v.flags[3] | v.flags[2];
    e.idx = idx;
    e.addr = modelPc;
    e.pc = v.expHalt ? modelPc : v.expPc;
    e.instret = v.expHalt ? modelInstret : modelInstret + 32'd1;
    if (v.expHalt) e.cycles = (v.flags[0] ? 2 : 3) + v.fetchWait;
    else e.cycles = 4 + v.fetchWait + (isMem ? 1 + v.memWait : 0);
    e.weCount = v.expWe ? 1 : 0;
    e.wbSel = v.expWbSel;
    e.halt = v.expHalt;
    e.memCycles = (isMem && !v.expHalt) ? 1 + v.memWait : 0;
    e.instr = v.word;
    sbq.push_back(e);
    modelPc = e.pc;
    modelInstret = e.instret;

    {jal, jalr, branch, mem_read, mem_write, reg_write, illegal} = v.flags;
    imm = v.imm; alu_result = v.alu; imem_rdata = v.word;
    o = '{default: 0};
    fc = 0; mc = 0; leftFetch = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (leftFetch && (imem_req || halted)) begin
        o.done = 1; o.cycles = c;
        break;
      end
      if (imem_req) begin
        if (c == 0) o.addr0 = imem_addr;
        else if (imem_addr !== o.addr0) o.addrMoved = 1;
        imem_ack = (fc == v.fetchWait);
        fc++;
      end else begin
        imem_ack = 1'b0;
        leftFetch = 1;
      end
      if (dmem_req) begin
        o.memCycles++;
        if (dmem_we !== v.flags[2] || alu_q !== v.alu) o.memBad = 1;
        dmem_ack = (mc == v.memWait);
        mc++;
      end else begin
        dmem_ack = 1'b0;
      end
      if (rf_we) begin
        o.weCount++;
        o.wbSel = wb_sel;
      end
      @(negedge clock);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    o.pc = pc; o.instret = instret; o.halted = halted; o.instr = instr;
  endtask

  task automatic checkOutput(input obs_t o);
    exp_t e;
    string p;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got an observation, required a queued expectation");
      return;
    end
    e = sbq.pop_front();
    p = $sformatf("v%0d", e.idx);
    if (!o.done) begin
      errors++;
      $display("[TB] FAIL %s timeout: no completion within %0d cycles", p, MAXC);
    end
    checkVal({p, " cycles"}, o.cycles, e.cycles);
    checkVal({p, " fetch addr"}, o.addr0, e.addr);
    checkVal({p, " addr stable"}, {31'b0, o.addrMoved}, 32'h0);
    checkVal({p, " rf_we pulses"}, o.weCount, e.weCount);
    if (e.weCount != 0) checkVal({p, " wb_sel"}, {30'b0, o.wbSel}, {30'b0, e.wbSel});
    checkVal({p, " mem cycles"}, o.memCycles, e.memCycles);
    checkVal({p, " mem signals"}, {31'b0, o.memBad}, 32'h0);
    checkVal({p, " pc"}, o.pc, e.pc);
    checkVal({p, " instret"}, o.instret, e.instret);
    checkVal({p, " halted"}, {31'b0, o.halted}, {31'b0, e.halt});
    checkVal({p, " instr"}, o.instr, e.instr);
  endtask

  // Halt must hold with outputs quiet and state frozen even if acks arrive.
  task automatic checkHaltHold(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d hold", idx);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkVal({p, " halted"}, {31'b0, halted}, 32'h1);
      checkVal({p, " reqs/we"}, {29'b0, imem_req, dmem_req, rf_we}, 32'h0);
      checkVal({p, " pc"}, pc, modelPc);
      checkVal({p, " instret"}, instret, modelInstret);
      checkVal({p, " instr"}, instr, v.word);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    obs_t o;
    bit found;
    reset = 1'b1;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
    {jal, jalr, branch, mem_read, mem_write, reg_write, illegal} = 7'b0;
    imm = 32'h0; alu_result = 32'h0;
    modelPc = RESET_PC; modelInstret = 32'h0;

    //     word          flags            imm           alu           fw mw expPc         we sel halt
    addVec(32'h00500093, F_RW,            32'd5,        32'd5,        0, 0, 32'h00000004, 1, 0, 0); // addi x1
    addVec(32'h00700113, F_RW,            32'd7,        32'd7,        3, 0, 32'h00000008, 1, 0, 0); // fetch stall
    addVec(32'h008000EF, F_JAL | F_RW,    32'd8,        32'h00012345, 0, 0, 32'h00000010, 1, 2, 0); // jal x1
    addVec(32'hFE000CE3, F_BR,            32'hFFFFFFF8, 32'd1,        0, 0, 32'h00000008, 0, 0, 0); // beq taken
    addVec(32'h0080006F, F_JAL | F_RW,    32'd8,        32'd0,        0, 0, 32'h00000010, 0, 2, 0); // jal x0
    addVec(32'hFE000CE3, F_BR,            32'hFFFFFFF8, 32'hFFFFFFFE, 0, 0, 32'h00000014, 0, 0, 0); // beq not taken
    addVec(32'h00112023, F_MW,            32'd0,        32'h00000100, 0, 2, 32'h00000018, 0, 0, 0); // sw, 2 waits
    addVec(32'h00402283, F_MR | F_RW,     32'd4,        32'h00000104, 0, 0, 32'h0000001C, 1, 1, 0); // lw x5
    addVec(32'h00002003, F_MR | F_RW,     32'd0,        32'h00000000, 0, 1, 32'h00000020, 0, 1, 0); // lw x0
    addVec(32'h00000013, F_RW,            32'd0,        32'd0,        0, 0, 32'h00000024, 0, 0, 0); // nop
    addVec(32'h000080E7, F_JALR | F_RW,   32'd0,        32'h00000041, 0, 0, 32'h00000040, 1, 2, 0); // jalr clears bit0
    addVec(32'h0000006F, F_JAL | F_RW,    32'hFFFFFFBC, 32'd0,        0, 0, 32'hFFFFFFFC, 0, 2, 0); // jal to top
    addVec(32'h00118193, F_RW,            32'd1,        32'd1,        0, 0, 32'h00000000, 1, 0, 0); // pc wraps
    addVec(32'h000080E7, F_JALR | F_RW,   32'd0,        32'h00000102, 0, 0, 32'h00000000, 0, 2, 1); // jalr misaligned
    addVec(32'h002081B3, F_RW,            32'd0,        32'd3,        1, 0, 32'h00000004, 1, 0, 0); // add after reset
    addVec(32'hFFFFFFFF, F_ILL,           32'd0,        32'd0,        0, 0, 32'h00000004, 0, 0, 1); // illegal
    addVec(32'h002000EF, F_JAL | F_RW,    32'd2,        32'd0,        0, 0, 32'h00000000, 0, 2, 1); // jal misaligned
    addVec(32'h00002303, F_MR | F_RW,     32'd0,        32'h00000208, 2, 3, 32'h00000004, 1, 1, 0); // lw, all waits

    doReset(1);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(i, vecs[i], o);
      checkOutput(o);
      if (vecs[i].expHalt) begin
        checkHaltHold(i, vecs[i]);
        doReset(0);
      end
    end

    // Reset arriving while a load is waiting on data memory.
    doReset(0);
    applyStimulus(0, vecs[0], o);
    checkOutput(o);
    {jal, jalr, branch, mem_read, mem_write, reg_write, illegal} = F_MR | F_RW;
    imm = 32'd4; alu_result = 32'h00000200; imem_rdata = 32'h00402283;
    imem_ack = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (!imem_req) imem_ack = 1'b0;
      if (dmem_req) found = 1;
    end
    checkVal("midmem reached MEM", {31'b0, found}, 32'h1);
    @(negedge clock);
    checkVal("midmem waiting req", {31'b0, dmem_req}, 32'h1);
    checkVal("midmem alu_q", alu_q, 32'h00000200);
    reset = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clock);
    checkVal("midmem dmem_req", {31'b0, dmem_req}, 32'h0);
    checkVal("midmem pc", pc, RESET_PC);
    checkVal("midmem instret", instret, 32'h0);
    checkVal("midmem imem_req", {31'b0, imem_req}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    dmem_ack = 1'b0;
    checkVal("midmem restart req", {31'b0, imem_req}, 32'h1);
    checkVal("midmem restart addr", imem_addr, RESET_PC);
    checkVal("midmem no dmem_req", {31'b0, dmem_req}, 32'h0);
    modelPc = RESET_PC; modelInstret = 32'h0;
    applyStimulus(0, vecs[0], o);
    checkOutput(o);

    checkVal("scoreboard drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
